seg_scroll_scan: RTL and testbench

//  Downstream consumer of the eclipse segment-pattern sequencer.

---
 rtl/seg_scroll_scan.sv | 93 +++++++++
 tb/tb_seg_scroll_scan.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/seg_scroll_scan.sv
// Scrolling segment buffer time-multiplexed onto a common-segment multi-digit 7-seg display.
// Optional macro SKIP_BLANK_EN: drop all-zero patterns instead of shifting them in.
module seg_scroll_scan #(
    parameter int unsigned NDIG     = 4,
    parameter int unsigned SCAN_DIV = 1000,
    parameter int unsigned DW       = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [6:0]      seg_in,
    input  logic            seg_valid,
    input  logic            clear,
    output logic [6:0]      seg_out,
    output logic [NDIG-1:0] an_out,
    output logic [DW-1:0]   digit_idx,
    output logic            scan_tick,
    output logic [7:0]      load_cnt
);

    localparam int unsigned SW = 7;
    localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned LW = 8;

    logic [NDIG-1:0][SW-1:0] seg_buf_q, seg_buf_d;
    logic [CW-1:0]           div_cnt_q, div_cnt_d;
    logic [DW-1:0]           digit_idx_q, digit_idx_d;
    logic [SW-1:0]           seg_out_q, seg_out_d;
    logic [NDIG-1:0]         an_out_q, an_out_d;
    logic                    scan_tick_q, scan_tick_d;
    logic [LW-1:0]           load_cnt_q, load_cnt_d;
    logic                    wrap;
    logic                    load_en;

    always_comb begin
        wrap = (div_cnt_q == CW'(SCAN_DIV - 1));
`ifdef SKIP_BLANK_EN
        load_en = seg_valid && !clear && (seg_in != '0);
`else
        load_en = seg_valid && !clear;
`endif

        div_cnt_d   = wrap ? '0 : div_cnt_q + CW'(1);
        digit_idx_d = digit_idx_q;
        if (wrap) begin
            digit_idx_d = (digit_idx_q == DW'(NDIG - 1)) ? '0 : digit_idx_q + DW'(1);
        end

        // Clear has priority over a same-cycle load; the scan counters are untouched.
        seg_buf_d  = seg_buf_q;
        load_cnt_d = load_cnt_q;
        if (clear) begin
            seg_buf_d  = '0;
            load_cnt_d = '0;
        end else if (load_en) begin
            seg_buf_d = {seg_buf_q[NDIG-2:0], seg_in};
            if (load_cnt_q != '1) begin
                load_cnt_d = load_cnt_q + LW'(1);
            end
        end

        // Anodes go dark for the first cycle of every slot to hide the segment-bus change.
        seg_out_d   = seg_buf_q[digit_idx_q];
        an_out_d    = wrap ? '1 : ~(NDIG'(1) << digit_idx_q);
        scan_tick_d = wrap;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_buf_q   <= '0;
            div_cnt_q   <= '0;
            digit_idx_q <= '0;
            seg_out_q   <= '0;
            an_out_q    <= '1;
            scan_tick_q <= 1'b0;
            load_cnt_q  <= '0;
        end else begin
            seg_buf_q   <= seg_buf_d;
            div_cnt_q   <= div_cnt_d;
            digit_idx_q <= digit_idx_d;
            seg_out_q   <= seg_out_d;
            an_out_q    <= an_out_d;
            scan_tick_q <= scan_tick_d;
            load_cnt_q  <= load_cnt_d;
        end
    end

    assign seg_out   = seg_out_q;
    assign an_out    = an_out_q;
    assign digit_idx = digit_idx_q;
    assign scan_tick = scan_tick_q;
    assign load_cnt  = load_cnt_q;

endmodule

// File: tb/tb_seg_scroll_scan.sv
// Scoreboard bench for seg_scroll_scan (NDIG=4, SCAN_DIV=4); honours SKIP_BLANK_EN.
module tb_seg_scroll_scan;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] seg_in;
    logic       seg_valid;
    logic       clear;
    logic [6:0] seg_out;
    logic [3:0] an_out;
    logic [1:0] digit_idx;
    logic       scan_tick;
    logic [7:0] load_cnt;

    seg_scroll_scan #(.NDIG(4), .SCAN_DIV(4), .DW(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg_in    (seg_in),
        .seg_valid (seg_valid),
        .clear     (clear),
        .seg_out   (seg_out),
        .an_out    (an_out),
        .digit_idx (digit_idx),
        .scan_tick (scan_tick),
        .load_cnt  (load_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] seg;
        logic [3:0] an;
        logic [1:0] idx;
        logic       tick;
        logic [7:0] cnt;
    } want_t;

    want_t      q[$];
    want_t      cur;
    int         n_chk  = 0;
    int         n_fail = 0;
    int         k      = 0;
    int         mcnt   = 0;
    logic [6:0] mbuf [4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    // Expected outputs after edge k follow from k alone: slot = k/4, dead cycle when k%4==0.
    task automatic cycle(input logic v, input logic [6:0] d, input logic c);
        want_t      w;
        logic [3:0] one;
        logic       ld;
        seg_valid = v;
        seg_in    = d;
        clear     = c;
        @(posedge clk);
        k++;
        one    = 4'b0001 << ((k / 4) % 4);
        w.seg  = mbuf[((k - 1) / 4) % 4];
        w.idx  = 2'((k / 4) % 4);
        w.tick = ((k % 4) == 0);
        w.an   = ((k % 4) == 0) ? 4'hF : ~one;
        ld = v && !c;
`ifdef SKIP_BLANK_EN
        if (d == 7'h00) ld = 1'b0;
`endif
        if (c) begin
            for (int i = 0; i < 4; i++) mbuf[i] = 7'h00;
            mcnt = 0;
        end else if (ld) begin
            for (int i = 3; i > 0; i--) mbuf[i] = mbuf[i-1];
            mbuf[0] = d;
            if (mcnt < 255) mcnt++;
        end
        w.cnt = 8'(mcnt);
        q.push_back(w);
        #1;
    endtask

    task automatic do_reset();
        seg_valid = 1'b0;
        clear     = 1'b0;
        seg_in    = 7'h00;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_an_out",    32'(an_out),    32'hF);
        chk("rst_seg_out",   32'(seg_out),   32'h0);
        chk("rst_digit_idx", 32'(digit_idx), 32'h0);
        chk("rst_load_cnt",  32'(load_cnt),  32'h0);
        chk("rst_scan_tick", 32'(scan_tick), 32'h0);
        @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        k    = 0;
        mcnt = 0;
        for (int i = 0; i < 4; i++) mbuf[i] = 7'h00;
    endtask

    // Observe 16 idle cycles and record which pattern is shown under each anode.
    task automatic scan_check(input string nm, input logic [6:0] e3, input logic [6:0] e2,
                              input logic [6:0] e1, input logic [6:0] e0);
        logic [6:0] seen [4];
        logic [6:0] ex   [4];
        logic [3:0] got;
        logic [3:0] m;
        ex[0] = e0; ex[1] = e1; ex[2] = e2; ex[3] = e3;
        got = 4'h0;
        for (int i = 0; i < 4; i++) seen[i] = 7'h00;
        repeat (16) begin
            cycle(1'b0, 7'h00, 1'b0);
            for (int i = 0; i < 4; i++) begin
                m = 4'b0001 << i;
                if (an_out == ~m) begin
                    seen[i] = seg_out;
                    got[i]  = 1'b1;
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_digit%0d_lit", nm, i), 32'(got[i]), 32'h1);
            chk($sformatf("%s_digit%0d_seg", nm, i), 32'(seen[i]), 32'(ex[i]));
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            cur = q.pop_front();
            chk("seg_out",   32'(seg_out),   32'(cur.seg));
            chk("an_out",    32'(an_out),    32'(cur.an));
            chk("digit_idx", 32'(digit_idx), 32'(cur.idx));
            chk("scan_tick", 32'(scan_tick), 32'(cur.tick));
            chk("load_cnt",  32'(load_cnt),  32'(cur.cnt));
            chk("an_single_low", 32'($countones(~an_out) <= 1), 32'h1);
        end
    end

    initial begin
        int ticks;
        rst_n     = 1'b1;
        seg_in    = 7'h00;
        seg_valid = 1'b0;
        clear     = 1'b0;
        for (int i = 0; i < 4; i++) mbuf[i] = 7'h00;
        do_reset();

        cycle(1'b1, 7'h79, 1'b0);
        cycle(1'b1, 7'h39, 1'b0);
        cycle(1'b1, 7'h38, 1'b0);
        cycle(1'b1, 7'h30, 1'b0);
        chk("cnt_after_4", 32'(load_cnt), 32'd4);
        scan_check("four_loads", 7'h79, 7'h39, 7'h38, 7'h30);

        cycle(1'b1, 7'h73, 1'b0);
        chk("cnt_after_5", 32'(load_cnt), 32'd5);
        scan_check("fifth_load", 7'h39, 7'h38, 7'h30, 7'h73);

        cycle(1'b1, 7'h6D, 1'b1);
        chk("cnt_after_clear", 32'(load_cnt), 32'd0);
        scan_check("cleared", 7'h00, 7'h00, 7'h00, 7'h00);

        do_reset();

        ticks = 0;
        repeat (16) begin
            cycle(1'b0, 7'h00, 1'b0);
            if (scan_tick) ticks++;
        end
        chk("tick_count_16", 32'(ticks), 32'd4);
        chk("idx_wrapped", 32'(digit_idx), 32'd0);

        cycle(1'b1, 7'h79, 1'b0);
        cycle(1'b1, 7'h00, 1'b0);
        cycle(1'b1, 7'h39, 1'b0);
`ifdef SKIP_BLANK_EN
        chk("cnt_blank_skip", 32'(load_cnt), 32'd2);
        scan_check("blank_skip", 7'h00, 7'h00, 7'h79, 7'h39);
`else
        chk("cnt_blank_keep", 32'(load_cnt), 32'd3);
        scan_check("blank_keep", 7'h00, 7'h79, 7'h00, 7'h39);
`endif

        repeat (300) cycle(1'b1, 7'h5B, 1'b0);
        chk("cnt_saturated", 32'(load_cnt), 32'd255);

        @(negedge clk);
        #1;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
